rnn_host_master: RTL

Bus master that drives the `rnn` accelerator's register port from the FPGA fabric side. It performs four steps in order:
- streams a parameter set (recurrent matrices, recurrent bias, dense vector, dense bias) into the accelerator's parameter window;
- writes the start command;
- polls the status register until done or timeout;
- reads back the result word.

It sits between a parameter source (on-chip ROM reader or HPS-fed FIFO) and the `rnn` slave. It is the initiator end of the accelerator's `read`/`write`/`addr`/`data_in`/`data_out` interface.

---
 rtl/rnn_host_master.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rnn_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rnn_host_master
// Brief   : Bus master that loads rnn parameters, starts inference, polls
//           status and fetches the result word.
// Revision: 1.0 - initial release
// ============================================================================
module rnn_host_master #(
    parameter int          N_PARAMS    = 161,
    parameter logic [31:0] PARAM_BASE  = 32'h100,
    parameter logic [31:0] CTRL_ADDR   = 32'h0,
    parameter logic [31:0] STATUS_ADDR = 32'h1,
    parameter logic [31:0] RESULT_ADDR = 32'h2,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        p_valid,
    input  logic [15:0] p_data,
    output logic        p_ready,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);
    localparam int IDX_W = $clog2(N_PARAMS + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] C_N = IDX_W'(N_PARAMS);
    localparam logic [CNT_W-1:0] C_T = CNT_W'(TIMEOUT);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_START     = 4'd2;
    localparam logic [3:0] S_POLL_REQ  = 4'd3;
    localparam logic [3:0] S_POLL_WAIT = 4'd4;
    localparam logic [3:0] S_RES_REQ   = 4'd5;
    localparam logic [3:0] S_RES_WAIT  = 4'd6;
    localparam logic [3:0] S_FIN       = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    logic [3:0]       r_state, w_next;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             w_accept;
    logic             w_p_ready, w_read, w_write, w_busy, w_done, w_err;
    logic [31:0]      w_addr, w_wdata, w_result;

    assign w_accept = (r_state == S_LOAD) && p_valid && p_ready;

    // Outputs are registered from the next state, so each state's bus
    // activity is visible in the same cycle the state register holds it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            p_ready <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            p_ready <= w_p_ready;
            m_read  <= w_read;
            m_write <= w_write;
            m_addr  <= w_addr;
            m_wdata <= w_wdata;
            busy    <= w_busy;
            done    <= w_done;
            err     <= w_err;
            result  <= w_result;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (go) w_next = S_LOAD;
            S_LOAD:      if (r_idx == C_N) w_next = S_START;
            S_START:     w_next = S_POLL_REQ;
            S_POLL_REQ:  w_next = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (m_rdata[0])       w_next = S_RES_REQ;
                else if (r_cnt == C_T) w_next = S_ERR;
                else                  w_next = S_POLL_REQ;
            end
            S_RES_REQ:   w_next = S_RES_WAIT;
            S_RES_WAIT:  w_next = S_FIN;
            S_FIN:       w_next = S_IDLE;
            S_ERR:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_p_ready = 1'b0;
        w_read    = 1'b0;
        w_write   = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_done    = 1'b0;
        w_err     = err;
        w_result  = result;
        w_idx     = r_idx;
        w_cnt     = r_cnt;
        w_busy    = (w_next != S_IDLE);

        if (r_state == S_IDLE && go) begin
            w_idx = '0;
            w_cnt = '0;
            w_err = 1'b0;
        end
        if (w_accept) begin
            w_write = 1'b1;
            w_addr  = PARAM_BASE + 32'(r_idx);
            w_wdata = {16'h0, p_data};
            if (r_idx != C_N) w_idx = r_idx + IDX_W'(1);
        end
        if (r_state == S_RES_WAIT) w_result = m_rdata;

        case (w_next)
            S_LOAD:     w_p_ready = (w_idx < C_N);
            S_START: begin
                w_write = 1'b1;
                w_addr  = CTRL_ADDR;
                w_wdata = 32'h1;
            end
            S_POLL_REQ: begin
                w_read = 1'b1;
                w_addr = STATUS_ADDR;
                if (r_cnt != C_T) w_cnt = r_cnt + CNT_W'(1);
            end
            S_RES_REQ: begin
                w_read = 1'b1;
                w_addr = RESULT_ADDR;
            end
            S_FIN:      w_done = 1'b1;
            S_ERR:      w_err  = 1'b1;
            default:    ;
        endcase
    end
endmodule
`default_nettype wire
